vlsu_axi_mem_responder: RTL



---
 rtl/vlsu_axi_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vlsu_axi_mem_responder.sv
// AXI4 responder backed by a single-port SRAM model for the VLSU master port.
// One outstanding read and one outstanding write; read and write FSMs are independent.
// Optional macro ARA_AXI_MEM_STALL_EN: a 16-bit LFSR throttles readiness and R valid.
module vlsu_axi_mem_responder #(
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiAddrWidth = 32,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned MemWords     = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [AxiIdWidth-1:0]     ar_id_i,
    input  logic [AxiAddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]                ar_len_i,
    input  logic [2:0]                ar_size_i,
    input  logic [1:0]                ar_burst_i,
    input  logic                      ar_valid_i,
    output logic                      ar_ready_o,
    output logic [AxiIdWidth-1:0]     r_id_o,
    output logic [AxiDataWidth-1:0]   r_data_o,
    output logic [1:0]                r_resp_o,
    output logic                      r_last_o,
    output logic                      r_valid_o,
    input  logic                      r_ready_i,
    input  logic [AxiIdWidth-1:0]     aw_id_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]                aw_len_i,
    input  logic [2:0]                aw_size_i,
    input  logic [1:0]                aw_burst_i,
    input  logic                      aw_valid_i,
    output logic                      aw_ready_o,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    input  logic                      w_valid_i,
    output logic                      w_ready_o,
    output logic [AxiIdWidth-1:0]     b_id_o,
    output logic [1:0]                b_resp_o,
    output logic                      b_valid_o,
    input  logic                      b_ready_i
);
    localparam int unsigned StrbWidth = AxiDataWidth / 8;
    localparam int unsigned OffW      = $clog2(StrbWidth);
    localparam int unsigned IdxW      = $clog2(MemWords);
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;
    localparam logic [1:0]  RespDecErr = 2'b11;
    localparam logic [1:0]  BurstIncr  = 2'b01;
    localparam logic [1:0]  BurstWrap  = 2'b10;

    typedef logic [AxiAddrWidth-1:0] addr_t;
    typedef enum logic {RIdle, RBurst} r_state_e;
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

    // Next beat address with carry-out; INCR aligns to size, others hold.
    function automatic logic [AxiAddrWidth:0] next_addr(addr_t a, logic [2:0] size,
                                                         logic [1:0] burst);
        addr_t step;
        addr_t mask;
        step = addr_t'(1) << size;
        mask = step - addr_t'(1);
        if (burst == BurstIncr) return {1'b0, a & ~mask} + {1'b0, step};
        return {1'b0, a};
    endfunction

    // Per-beat code before any w_last check; a wrapped address is out of range.
    function automatic logic [1:0] beat_resp(addr_t a, logic wrapped, logic [1:0] burst);
        if (wrapped || (a[AxiAddrWidth-1:OffW+IdxW] != '0)) return RespDecErr;
        if (burst == BurstWrap) return RespSlvErr;
        return RespOkay;
    endfunction

    logic [AxiDataWidth-1:0] mem_q [MemWords];
    logic live_q;
    logic rdy_gate, rv_gate;

    // Readies stay low until the cycle after reset is released.
    always_ff @(posedge clk_i) begin
        if (rst_i) live_q <= 1'b0;
        else       live_q <= 1'b1;
    end

`ifdef ARA_AXI_MEM_STALL_EN
    logic [15:0] lfsr_q;
    logic        r_shown_q;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advancing every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= 16'hACE1;
        else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // Remember a raised r_valid_o so it holds until the handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i)                        r_shown_q <= 1'b0;
        else if (r_valid_o && r_ready_i)  r_shown_q <= 1'b0;
        else if (r_valid_o)               r_shown_q <= 1'b1;
    end

    assign rdy_gate = lfsr_q[0];
    assign rv_gate  = lfsr_q[1] | r_shown_q;
`else
    assign rdy_gate = 1'b1;
    assign rv_gate  = 1'b1;
`endif

    // ---------------- read side ----------------
    r_state_e                r_state_q, r_state_d;
    addr_t                   r_addr_q, rd_addr;
    logic [7:0]              r_cnt_q, r_len_q;
    logic [2:0]              r_size_q;
    logic [1:0]              r_burst_q, rd_burst, r_resp_q, rd_resp;
    logic [AxiIdWidth-1:0]   r_id_q;
    logic [AxiDataWidth-1:0] r_data_q;
    logic                    r_wrap_q, rd_wrap, rd_carry, rd_ld;

    assign r_last_o = (r_state_q == RBurst) && (r_cnt_q == r_len_q);
    assign rd_resp  = beat_resp(rd_addr, rd_wrap, rd_burst);

    // Read next-state, handshake outputs and the address of the word to fetch.
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        rd_ld      = 1'b0;
        rd_addr    = r_addr_q;
        rd_burst   = r_burst_q;
        rd_wrap    = r_wrap_q;
        rd_carry   = 1'b0;
        case (r_state_q)
            RIdle: begin
                ar_ready_o = live_q & rdy_gate;
                if (ar_valid_i && ar_ready_o) begin
                    r_state_d = RBurst;
                    rd_ld     = 1'b1;
                    rd_addr   = ar_addr_i;
                    rd_burst  = ar_burst_i;
                    rd_wrap   = 1'b0;
                end
            end
            RBurst: begin
                r_valid_o = rv_gate;
                if (r_valid_o && r_ready_i) begin
                    if (r_last_o) begin
                        r_state_d = RIdle;
                    end else begin
                        rd_ld               = 1'b1;
                        {rd_carry, rd_addr} = next_addr(r_addr_q, r_size_q, r_burst_q);
                        rd_wrap             = r_wrap_q | rd_carry;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    // Read state, burst context and the registered beat payload.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= RIdle;
            r_addr_q  <= '0;
            r_cnt_q   <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= RespOkay;
            r_wrap_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_valid_i && ar_ready_o) begin
                r_id_q    <= ar_id_i;
                r_len_q   <= ar_len_i;
                r_size_q  <= ar_size_i;
                r_burst_q <= ar_burst_i;
                r_cnt_q   <= '0;
            end else if (r_valid_o && r_ready_i) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
            if (rd_ld) begin
                r_addr_q <= rd_addr;
                r_wrap_q <= rd_wrap;
                r_resp_q <= rd_resp;
                r_data_q <= (rd_resp == RespOkay) ? mem_q[rd_addr[OffW +: IdxW]] : '0;
            end
        end
    end

    assign r_id_o   = r_id_q;
    assign r_data_o = r_data_q;
    assign r_resp_o = r_resp_q;

    // ---------------- write side ----------------
    w_state_e              w_state_q, w_state_d;
    addr_t                 w_addr_q, wr_next;
    logic [7:0]            w_cnt_q, w_len_q;
    logic [2:0]            w_size_q;
    logic [1:0]            w_burst_q, b_resp_q, wr_base, wr_code;
    logic [AxiIdWidth-1:0] b_id_q;
    logic                  w_wrap_q, wr_carry, wr_hs;

    assign wr_hs              = w_valid_i && w_ready_o;
    assign wr_base            = beat_resp(w_addr_q, w_wrap_q, w_burst_q);
    assign {wr_carry, wr_next} = next_addr(w_addr_q, w_size_q, w_burst_q);

    // A w_last that disagrees with the beat count raises the beat to SLVERR.
    always_comb begin
        wr_code = wr_base;
        if ((w_last_i != (w_cnt_q == w_len_q)) && (wr_base == RespOkay)) wr_code = RespSlvErr;
    end

    // Write next-state and handshake outputs.
    always_comb begin
        w_state_d  = w_state_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        case (w_state_q)
            WIdle: begin
                aw_ready_o = live_q & rdy_gate;
                if (aw_valid_i && aw_ready_o) w_state_d = WData;
            end
            WData: begin
                w_ready_o = rdy_gate;
                if (wr_hs && w_last_i) w_state_d = WResp;
            end
            WResp: begin
                b_valid_o = 1'b1;
                if (b_ready_i) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Write state, burst context and worst-case response accumulation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_q <= WIdle;
            w_addr_q  <= '0;
            w_cnt_q   <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_wrap_q  <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            if (aw_valid_i && aw_ready_o) begin
                w_addr_q  <= aw_addr_i;
                w_len_q   <= aw_len_i;
                w_size_q  <= aw_size_i;
                w_burst_q <= aw_burst_i;
                w_cnt_q   <= '0;
                w_wrap_q  <= 1'b0;
                b_id_q    <= aw_id_i;
                b_resp_q  <= RespOkay;
            end else if (wr_hs) begin
                w_addr_q <= wr_next;
                w_wrap_q <= w_wrap_q | wr_carry;
                w_cnt_q  <= w_cnt_q + 8'd1;
                // Codes are numerically ordered DECERR > SLVERR > OKAY.
                if (wr_code > b_resp_q) b_resp_q <= wr_code;
            end
        end
    end

    // SRAM byte-lane writes; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_hs && (wr_base == RespOkay)) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (w_strb_i[b]) mem_q[w_addr_q[OffW +: IdxW]][8*b +: 8] <= w_data_i[8*b +: 8];
            end
        end
    end

    assign b_id_o   = b_id_q;
    assign b_resp_o = b_resp_q;

endmodule
